// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Multi-cycle, one quotient bit per clock, registered result.
module iter_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  output logic                  busy,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvsr;
  logic          rem_sel;
  logic          q_sign;
  logic          r_sign;

  logic          ready;
  logic          accept;
  logic          sgn;
  logic          a_neg;
  logic          b_neg;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic          div_zero;
  logic          ovf;
  logic          special;
  logic [W-1:0]  sp_res;

  logic [W:0]    shifted;
  logic [W-1:0]  diff;
  logic          take;
  logic [W-1:0]  r_nxt;
  logic [W-1:0]  q_nxt;
  logic [W-1:0]  fin_q;
  logic [W-1:0]  fin_r;
  logic [W-1:0]  fin;
  logic          last;

  assign ready  = (state != CALC);
  assign accept = ready && start && !flush;
  assign busy   = (state == CALC);
  assign valid  = (state == DONE);

  assign sgn   = ~div_op[0];
  assign a_neg = sgn & op1[W-1];
  assign b_neg = sgn & op2[W-1];
  assign a_mag = a_neg ? -op1 : op1;
  assign b_mag = b_neg ? -op2 : op2;

  assign div_zero = (op2 == '0);
  assign ovf      = sgn
                  && (op1 == {1'b1, {(W-1){1'b0}}})
                  && (op2 == '1);
  assign special  = div_zero | ovf;

  always_comb begin
    sp_res = '0;
    unique case (1'b1)
      div_zero: sp_res = div_op[1] ? op1 : '1;
      default:  sp_res = div_op[1] ? '0 : op1;
    endcase
  end

  // Shifted partial remainder is W+1 bits so large unsigned divisors compare correctly
  assign shifted = {rem, quo[W-1]};
  assign take    = (shifted >= {1'b0, dvsr});
  assign diff    = shifted[W-1:0] - dvsr;
  assign r_nxt   = take ? diff : shifted[W-1:0];
  assign q_nxt   = {quo[W-2:0], take};

  assign fin_q = q_sign ? -q_nxt : q_nxt;
  assign fin_r = r_sign ? -r_nxt : r_nxt;
  assign fin   = rem_sel ? fin_r : fin_q;
  assign last  = (state == CALC) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = special ? DONE : CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        if (accept) state_nxt = special ? DONE : CALC;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      rem_sel <= 1'b0;
      q_sign  <= 1'b0;
      r_sign  <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      rem_sel <= div_op[1];
      q_sign  <= a_neg ^ b_neg;
      r_sign  <= a_neg;
      rem     <= '0;
      quo     <= a_mag;
      dvsr    <= b_mag;
      cnt     <= CW'(W - 1);
      if (special) result <= sp_res;
    end else if (state == CALC) begin
      rem <= r_nxt;
      quo <= q_nxt;
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (last) result <= fin;
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// Scoreboard bench for iter_div_unit: directed RV32M cases,
// handshake/abort scenarios and randomized ops vs. an arithmetic model.
module tb_iter_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  div_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  iter_div_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .div_op (div_op),
    .op1    (op1),
    .op2    (op2),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          errs;
  int          checks;
  int          cyc;
  logic [31:0] last_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding op
  always @(negedge clk) begin
    if (rst_n && valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errs++;
        $display("FAIL unexpected_valid result=%h", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        last_res = e.res;
        if (result !== e.res) begin
          errs++;
          $display("FAIL result got=%h want=%h", result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          errs++;
          $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
        end
      end
    end
  end

  // Called at a negedge while the unit is ready
  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    exp_t e;
    bit   sp;
    sp = (b == 32'd0) ||
         (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    e.res = model(op, a, b);
    e.cyc = cyc + 1 + (sp ? 0 : 32);
    sbq.push_back(e);
    start  = 1'b1;
    div_op = op;
    op1    = a;
    op2    = b;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    op1    = $urandom;
    op2    = $urandom;
    div_op = 2'($urandom);
    checks++;
    if (busy !== !sp) begin
      errs++;
      $display("FAIL busy_after_accept got=%0b want=%0b", busy, !sp);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout pending=%0d want=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run(input logic [1:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b);
    issue(op, a, b);
    drain();
  endtask

  task automatic check_idle(input string name, input logic [31:0] want);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== want) begin
      errs++;
      $display("FAIL %s busy=%0b valid=%0b result=%h want 0/0/%h",
               name, busy, valid, result, want);
    end
  endtask

  initial begin
    int n;
    errs     = 0;
    checks   = 0;
    last_res = 32'd0;
    rst_n    = 1'b0;
    start    = 1'b0;
    flush    = 1'b0;
    div_op   = 2'b00;
    op1      = 32'd0;
    op2      = 32'd0;
    repeat (3) @(negedge clk);
    check_idle("reset", 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(2'b00, 32'd20, 32'd5);
    run(2'b00, 32'hFFFF_FFEC, 32'd5);
    run(2'b10, 32'd20, 32'd5);
    run(2'b10, 32'hFFFF_FFEC, 32'd5);
    run(2'b10, 32'd20, 32'd6);
    run(2'b10, 32'hFFFF_FFEC, 32'd6);
    run(2'b01, 32'hFFFF_FFFE, 32'd2);
    run(2'b11, 32'h8000_0001, 32'h8000_0000);
    run(2'b00, 32'd20, 32'd0);
    run(2'b10, 32'd20, 32'd0);
    run(2'b01, 32'd0, 32'd0);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b11, 32'h7, 32'hFFFF_FFFF);
    run(2'b00, 32'hFFFF_FFEC, 32'hFFFF_FFFB);

    // start during CALC must be ignored
    issue(2'b00, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    start  = 1'b1;
    div_op = 2'b01;
    op1    = 32'd99;
    op2    = 32'd0;
    repeat (5) @(negedge clk);
    start = 1'b0;
    drain();

    // back-to-back: start held in the DONE cycle
    issue(2'b00, 32'd100, 32'd7);
    n = 0;
    while (!valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    issue(2'b00, 32'hFFFF_FF9C, 32'd7);
    drain();

    // flush mid-CALC; coincident start must be dropped
    run(2'b00, 32'd20, 32'd5);
    issue(2'b00, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    op1   = 32'd9;
    op2   = 32'd3;
    void'(sbq.pop_back());
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    check_idle("flush", 32'd4);
    repeat (40) @(negedge clk);
    check_idle("flush_hold", 32'd4);
    run(2'b10, 32'd1000, 32'd7);

    // reset mid-CALC
    issue(2'b01, 32'd77, 32'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    void'(sbq.pop_back());
    @(posedge clk);
    @(negedge clk);
    check_idle("reset_mid_calc", 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run(2'b01, 32'd77, 32'd7);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 1000);
        4: b = {1'b1, 31'($urandom)};
        default: ;
      endcase
      run(op, a, b);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog elapsed=2000000 want=finish");
    $fatal(1, "watchdog");
  end

endmodule
